// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer.
// All outputs are registered; in_ready has no combinational path from out_ready.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned RD_W   = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rs2,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu,
    output logic [DATA_W-1:0] out_rs2,
    output logic [RD_W-1:0]   out_rd,
    output logic              out_wen,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned PayW = 2 * DATA_W + RD_W + 1;

    typedef enum logic [1:0] {StEmpty, StBusy, StFull} state_e;

    state_e            state_q;
    logic [PayW-1:0]   main_q;
    logic [PayW-1:0]   skid_q;
    logic [PayW-1:0]   in_pay;
    logic              accept;
    logic              fire;

    assign in_pay = {in_alu, in_rs2, in_rd, in_wen};
    assign accept = in_valid && in_ready;
    assign fire   = out_valid && out_ready;

    assign {out_alu, out_rs2, out_rd, out_wen} = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StEmpty;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
            stall_cnt <= '0;
        end else begin
            // Counts flush cycles too; saturates rather than wrapping.
            if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end

            if (flush) begin
                state_q   <= StEmpty;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            main_q    <= in_pay;
                            state_q   <= StBusy;
                            out_valid <= 1'b1;
                        end
                    end
                    StBusy: begin
                        if (accept && fire) begin
                            main_q <= in_pay;
                        end else if (accept) begin
                            // Downstream stalled: park the newer entry behind main.
                            skid_q   <= in_pay;
                            state_q  <= StFull;
                            in_ready <= 1'b0;
                        end else if (fire) begin
                            state_q   <= StEmpty;
                            out_valid <= 1'b0;
                        end
                    end
                    StFull: begin
                        if (fire) begin
                            main_q   <= skid_q;
                            state_q  <= StBusy;
                            in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= StEmpty;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
